// File: rtl/ibex_pmp_checker.sv
// Registered multi-channel PMP checker with valid/ready request and
// response channels, sticky first-fault capture and a fault counter.
package ibex_pmp_pkg;

   typedef enum logic [1:0] {
      PMP_MODE_OFF   = 2'b00,
      PMP_MODE_TOR   = 2'b01,
      PMP_MODE_NA4   = 2'b10,
      PMP_MODE_NAPOT = 2'b11
   } pmp_cfg_mode_e;

   typedef struct packed {
      logic          lock;
      pmp_cfg_mode_e mode;
      logic          exec;
      logic          write;
      logic          read;
   } pmp_cfg_t;

   typedef enum logic [1:0] {
      PRIV_LVL_U = 2'b00,
      PRIV_LVL_S = 2'b01,
      PRIV_LVL_H = 2'b10,
      PRIV_LVL_M = 2'b11
   } priv_lvl_e;

   typedef enum logic [1:0] {
      PMP_ACC_EXEC  = 2'b00,
      PMP_ACC_WRITE = 2'b01,
      PMP_ACC_READ  = 2'b10
   } pmp_req_e;

endpackage

module ibex_pmp_checker
   import ibex_pmp_pkg::*;
#(
   parameter int PMPGranularity = 0,
   parameter int PMPNumChan     = 2,
   parameter int PMPNumRegions  = 4,
   parameter int PMPAddrWidth   = 34,
   localparam int RW = (PMPNumRegions > 1) ? $clog2(PMPNumRegions) : 1,
   localparam int CW = (PMPNumChan > 1) ? $clog2(PMPNumChan) : 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  pmp_cfg_t                csr_pmp_cfg_i  [PMPNumRegions],
   input  logic [PMPAddrWidth-1:0] csr_pmp_addr_i [PMPNumRegions],
   input  priv_lvl_e               priv_mode_i    [PMPNumChan],
   input  logic [PMPNumChan-1:0]   pmp_req_valid_i,
   output logic [PMPNumChan-1:0]   pmp_req_ready_o,
   input  logic [PMPAddrWidth-1:0] pmp_req_addr_i [PMPNumChan],
   input  pmp_req_e                pmp_req_type_i [PMPNumChan],
   output logic [PMPNumChan-1:0]   pmp_rsp_valid_o,
   input  logic [PMPNumChan-1:0]   pmp_rsp_ready_i,
   output logic [PMPNumChan-1:0]   pmp_rsp_err_o,
   output logic [RW-1:0]           pmp_rsp_region_o [PMPNumChan],
   output logic [PMPNumChan-1:0]   pmp_rsp_hit_o,
   output logic                    fault_valid_o,
   output logic [PMPAddrWidth-1:0] fault_addr_o,
   output logic [CW-1:0]           fault_chan_o,
   output pmp_req_e                fault_type_o,
   output logic [15:0]             fault_count_o,
   input  logic                    fault_clear_i
);

   localparam int AW = PMPAddrWidth;
   localparam int NC = PMPNumChan;
   localparam int NR = PMPNumRegions;
   localparam int GS = PMPGranularity + 2;

   // 1 marks an address bit that takes part in a NAPOT compare.
   function automatic logic [AW-1:0] napot_mask_f(
      input logic [AW-1:0] csr
   );
      logic [AW-1:0] eff;
      logic [AW-1:0] m;
      logic          run;
      eff = csr;
      m   = '0;
      run = 1'b1;
      for (int j = 2; j < GS; j++) eff[j] = 1'b1;
      for (int j = 2; j < AW; j++) begin
         m[j] = ~run;
         run  = run & eff[j];
      end
      return m;
   endfunction

   function automatic logic match_f(
      input pmp_cfg_mode_e mode,
      input logic [AW-1:0] addr,
      input logic [AW-1:0] csr,
      input logic [AW-1:0] prev
   );
      logic [AW-1:0] a_g;
      logic [AW-1:0] c_g;
      logic [AW-1:0] p_g;
      a_g = addr >> GS;
      c_g = csr >> GS;
      p_g = prev >> GS;
      case (mode)
         PMP_MODE_TOR:
            return (a_g >= p_g) && (a_g < c_g);
         PMP_MODE_NA4:
            return (PMPGranularity == 0) &&
                   (addr[AW-1:2] == csr[AW-1:2]);
         PMP_MODE_NAPOT:
            return ((addr ^ csr) & napot_mask_f(csr)) == '0;
         default:
            return 1'b0;
      endcase
   endfunction

   function automatic logic perm_f(
      input pmp_cfg_t cfg,
      input pmp_req_e t
   );
      case (t)
         PMP_ACC_EXEC:  return cfg.exec;
         PMP_ACC_WRITE: return cfg.write;
         PMP_ACC_READ:  return cfg.read;
         default:       return 1'b0;
      endcase
   endfunction

   logic [AW-1:0] prev_addr [NR];
   logic [NC-1:0] accept;
   logic [NC-1:0] dec_err;
   logic [NC-1:0] dec_hit;
   logic [NC-1:0] sel_lock;
   logic [NC-1:0] sel_perm;
   logic [RW-1:0] dec_region [NC];

   always_comb begin
      prev_addr[0] = '0;
      for (int r = 1; r < NR; r++) begin
         prev_addr[r] = csr_pmp_addr_i[r-1];
      end
   end

   assign pmp_req_ready_o = {NC{~rst_i}} &
                            (~pmp_rsp_valid_o | pmp_rsp_ready_i);
   assign accept = pmp_req_valid_i & pmp_req_ready_o;

   // Scan high to low so the lowest matching region is the one kept.
   always_comb begin
      for (int c = 0; c < NC; c++) begin
         dec_hit[c]    = 1'b0;
         dec_err[c]    = 1'b0;
         sel_lock[c]   = 1'b0;
         sel_perm[c]   = 1'b0;
         dec_region[c] = '0;
         for (int r = NR - 1; r >= 0; r--) begin
            if (match_f(csr_pmp_cfg_i[r].mode, pmp_req_addr_i[c],
                        csr_pmp_addr_i[r], prev_addr[r])) begin
               dec_hit[c]    = 1'b1;
               dec_region[c] = RW'(r);
               sel_lock[c]   = csr_pmp_cfg_i[r].lock;
               sel_perm[c]   = perm_f(csr_pmp_cfg_i[r],
                                      pmp_req_type_i[c]);
            end
         end
         if (priv_mode_i[c] == PRIV_LVL_M) begin
            dec_err[c] = dec_hit[c] & sel_lock[c] & ~sel_perm[c];
         end else begin
            dec_err[c] = ~(dec_hit[c] & sel_perm[c]);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pmp_rsp_valid_o <= '0;
         pmp_rsp_err_o   <= '0;
         pmp_rsp_hit_o   <= '0;
         for (int c = 0; c < NC; c++) begin
            pmp_rsp_region_o[c] <= '0;
         end
      end else begin
         for (int c = 0; c < NC; c++) begin
            if (accept[c]) begin
               pmp_rsp_valid_o[c]  <= 1'b1;
               pmp_rsp_err_o[c]    <= dec_err[c];
               pmp_rsp_hit_o[c]    <= dec_hit[c];
               pmp_rsp_region_o[c] <= dec_region[c];
            end else if (pmp_rsp_ready_i[c]) begin
               pmp_rsp_valid_o[c] <= 1'b0;
            end
         end
      end
   end

   logic [NC-1:0] ev;
   logic [CW-1:0] ev_chan;
   logic [AW-1:0] ev_addr;
   pmp_req_e      ev_type;
   logic [4:0]    ev_cnt;
   logic [16:0]   cnt_sum;
   logic [15:0]   cnt_nxt;

   always_comb begin
      ev      = accept & dec_err;
      ev_chan = '0;
      ev_addr = '0;
      ev_type = PMP_ACC_EXEC;
      ev_cnt  = '0;
      for (int c = NC - 1; c >= 0; c--) begin
         if (ev[c]) begin
            ev_chan = CW'(c);
            ev_addr = pmp_req_addr_i[c];
            ev_type = pmp_req_type_i[c];
         end
      end
      for (int c = 0; c < NC; c++) begin
         ev_cnt = ev_cnt + 5'(ev[c]);
      end
      cnt_sum = (fault_clear_i ? 17'd0 : {1'b0, fault_count_o}) +
                17'(ev_cnt);
      cnt_nxt = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fault_valid_o <= 1'b0;
         fault_addr_o  <= '0;
         fault_chan_o  <= '0;
         fault_type_o  <= PMP_ACC_EXEC;
         fault_count_o <= '0;
      end else begin
         fault_count_o <= cnt_nxt;
         if (|ev && (!fault_valid_o || fault_clear_i)) begin
            fault_valid_o <= 1'b1;
            fault_addr_o  <= ev_addr;
            fault_chan_o  <= ev_chan;
            fault_type_o  <= ev_type;
         end else if (fault_clear_i) begin
            fault_valid_o <= 1'b0;
            fault_addr_o  <= '0;
            fault_chan_o  <= '0;
            fault_type_o  <= PMP_ACC_EXEC;
         end
      end
   end

endmodule

// File: tb/tb_ibex_pmp_checker.sv
// Scoreboard bench for ibex_pmp_checker: expected responses and
// status snapshots are queued by stimulus and checked by a monitor.
module tb_ibex_pmp_checker;
   import ibex_pmp_pkg::*;

   localparam int NCH = 2;
   localparam int NREG = 4;
   localparam int AW = 34;
   localparam int RW = 2;
   localparam int CW = 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pmp_cfg_t          cfg [NREG];
   logic [AW-1:0]     csr_addr [NREG];
   priv_lvl_e         priv [NCH];
   logic [NCH-1:0]    req_valid, req_ready;
   logic [NCH-1:0]    rsp_valid, rsp_ready, rsp_err, rsp_hit;
   logic [AW-1:0]     req_addr [NCH];
   pmp_req_e          req_type [NCH];
   logic [RW-1:0]     rsp_region [NCH];
   logic              fault_valid;
   logic [AW-1:0]     fault_addr;
   logic [CW-1:0]     fault_chan;
   pmp_req_e          fault_type;
   logic [15:0]       fault_count;
   logic              fault_clear;

   int checks = 0;
   int errors = 0;

   logic [RW+1:0] q0[$];
   logic [RW+1:0] q1[$];
   int            kind_q[$];
   logic [63:0]   val_q[$];
   string         name_q[$];

   ibex_pmp_checker #(
      .PMPGranularity(0),
      .PMPNumChan    (NCH),
      .PMPNumRegions (NREG),
      .PMPAddrWidth  (AW)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .csr_pmp_cfg_i   (cfg),
      .csr_pmp_addr_i  (csr_addr),
      .priv_mode_i     (priv),
      .pmp_req_valid_i (req_valid),
      .pmp_req_ready_o (req_ready),
      .pmp_req_addr_i  (req_addr),
      .pmp_req_type_i  (req_type),
      .pmp_rsp_valid_o (rsp_valid),
      .pmp_rsp_ready_i (rsp_ready),
      .pmp_rsp_err_o   (rsp_err),
      .pmp_rsp_region_o(rsp_region),
      .pmp_rsp_hit_o   (rsp_hit),
      .fault_valid_o   (fault_valid),
      .fault_addr_o    (fault_addr),
      .fault_chan_o    (fault_chan),
      .fault_type_o    (fault_type),
      .fault_count_o   (fault_count),
      .fault_clear_i   (fault_clear)
   );

   function automatic pmp_cfg_t mk(logic l, pmp_cfg_mode_e m,
                                   logic x, logic w, logic r);
      pmp_cfg_t c;
      c.lock  = l;
      c.mode  = m;
      c.exec  = x;
      c.write = w;
      c.read  = r;
      return c;
   endfunction

   // ---------------- monitor ----------------
   task automatic check(string n, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", n, act, exp);
      end
   endtask

   function automatic logic [63:0] sample(int k);
      case (k)
         0: return 64'(fault_valid);
         1: return 64'(fault_chan);
         2: return 64'(fault_addr);
         3: return 64'(fault_type);
         4: return 64'(fault_count);
         5: return 64'(req_ready);
         6: return 64'(rsp_valid);
         7: return 64'({rsp_err[0], rsp_hit[0], rsp_region[0]});
         8: return 64'({rsp_err[1], rsp_hit[1], rsp_region[1]});
         9: return 64'(q0.size() + q1.size());
         default: return '1;
      endcase
   endfunction

   always @(negedge clk) begin
      int k;
      logic [63:0] v;
      string n;
      while (kind_q.size() > 0) begin
         k = kind_q.pop_front();
         v = val_q.pop_front();
         n = name_q.pop_front();
         check(n, sample(k), v);
      end
      if (rst) begin
         q0.delete();
         q1.delete();
      end else begin
         if (rsp_valid[0] && rsp_ready[0]) begin
            if (q0.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL ch0 rsp: got unexpected response, expected none");
            end else begin
               check("ch0 rsp", {rsp_err[0], rsp_hit[0], rsp_region[0]},
                     64'(q0.pop_front()));
            end
         end
         if (rsp_valid[1] && rsp_ready[1]) begin
            if (q1.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL ch1 rsp: got unexpected response, expected none");
            end else begin
               check("ch1 rsp", {rsp_err[1], rsp_hit[1], rsp_region[1]},
                     64'(q1.pop_front()));
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(int ch, priv_lvl_e p, logic [AW-1:0] a,
                      pmp_req_e t, logic e, logic h, logic [RW-1:0] g);
      req_valid[ch] = 1'b1;
      priv[ch]      = p;
      req_addr[ch]  = a;
      req_type[ch]  = t;
      if (ch == 0) q0.push_back({e, h, g});
      else         q1.push_back({e, h, g});
   endtask

   task automatic exp_st(int k, logic [63:0] v, string n);
      kind_q.push_back(k);
      val_q.push_back(v);
      name_q.push_back(n);
   endtask

   initial begin
      rst         = 1'b1;
      req_valid   = '0;
      rsp_ready   = '1;
      fault_clear = 1'b0;
      for (int i = 0; i < NREG; i++) begin
         cfg[i]      = mk(0, PMP_MODE_OFF, 0, 0, 0);
         csr_addr[i] = '0;
      end
      for (int i = 0; i < NCH; i++) begin
         priv[i]     = PRIV_LVL_M;
         req_addr[i] = '0;
         req_type[i] = PMP_ACC_READ;
      end
      tick();
      tick();
      exp_st(5, 0, "reset req_ready");
      exp_st(6, 0, "reset rsp_valid");
      exp_st(7, 0, "reset rsp ch0");
      exp_st(8, 0, "reset rsp ch1");
      exp_st(0, 0, "reset fault_valid");
      exp_st(4, 0, "reset fault_count");
      tick();
      rst = 1'b0;
      exp_st(5, 3, "ready after release");

      cfg[0] = mk(0, PMP_MODE_NAPOT, 1, 0, 1);
      csr_addr[0] = 34'h0FFC;
      cfg[1] = mk(0, PMP_MODE_TOR, 0, 1, 1);
      csr_addr[1] = 34'h4000;
      cfg[2] = mk(0, PMP_MODE_NA4, 0, 0, 1);
      csr_addr[2] = 34'h5000;
      tick();

      // back-to-back directed vectors on both channels
      req(0, PRIV_LVL_U, 34'h1000, PMP_ACC_WRITE, 1, 1, 0);
      req(1, PRIV_LVL_U, 34'h2000, PMP_ACC_WRITE, 0, 1, 1);
      tick();
      req(0, PRIV_LVL_M, 34'h8000, PMP_ACC_READ, 0, 0, 0);
      req(1, PRIV_LVL_U, 34'h8000, PMP_ACC_READ, 1, 0, 0);
      tick();
      req(0, PRIV_LVL_U, 34'h0100, PMP_ACC_EXEC, 0, 1, 0);
      req(1, PRIV_LVL_U, 34'h3FFF, PMP_ACC_READ, 0, 1, 1);
      tick();
      req(0, PRIV_LVL_U, 34'h4000, PMP_ACC_READ, 1, 0, 0);
      req(1, PRIV_LVL_U, 34'h5002, PMP_ACC_READ, 0, 1, 2);
      tick();
      req(0, PRIV_LVL_U, 34'h5004, PMP_ACC_READ, 1, 0, 0);
      req(1, PRIV_LVL_S, 34'h3000, PMP_ACC_WRITE, 0, 1, 1);
      tick();
      req(0, PRIV_LVL_U, 34'h1FFC, PMP_ACC_WRITE, 1, 1, 0);
      req(1, PRIV_LVL_U, 34'h3000, PMP_ACC_EXEC, 1, 1, 1);
      tick();
      cfg[0] = mk(1, PMP_MODE_NAPOT, 1, 0, 1);
      req(0, PRIV_LVL_M, 34'h0000, PMP_ACC_WRITE, 1, 1, 0);
      req(1, PRIV_LVL_M, 34'h0000, PMP_ACC_READ, 0, 1, 0);
      tick();
      cfg[0] = mk(0, PMP_MODE_NAPOT, 1, 0, 1);
      req(0, PRIV_LVL_M, 34'h0000, PMP_ACC_WRITE, 0, 1, 0);
      req(1, PRIV_LVL_M, 34'h2000, PMP_ACC_EXEC, 0, 1, 1);
      tick();
      req_valid = '0;
      tick();

      // backpressure on channel 0
      rsp_ready[0] = 1'b0;
      req(0, PRIV_LVL_U, 34'h0100, PMP_ACC_READ, 0, 1, 0);
      tick();
      exp_st(5, 2'b10, "held req_ready");
      exp_st(6, 2'b01, "held rsp_valid 1");
      exp_st(7, 4'b0100, "held rsp 1");
      cfg[0] = mk(0, PMP_MODE_OFF, 1, 0, 1);
      tick();
      exp_st(6, 2'b01, "held rsp_valid 2");
      exp_st(7, 4'b0100, "held rsp 2");
      tick();
      exp_st(6, 2'b01, "held rsp_valid 3");
      exp_st(7, 4'b0100, "held rsp 3");
      rsp_ready[0] = 1'b1;
      req(0, PRIV_LVL_U, 34'h0100, PMP_ACC_READ, 1, 0, 0);
      tick();
      req_valid = '0;
      exp_st(6, 2'b01, "next rsp_valid");
      exp_st(7, 4'b1000, "next rsp");
      tick();
      cfg[0] = mk(0, PMP_MODE_NAPOT, 1, 0, 1);
      tick();

      // fault capture
      fault_clear = 1'b1;
      tick();
      fault_clear = 1'b0;
      exp_st(0, 0, "clr fault_valid");
      exp_st(4, 0, "clr count");
      req(0, PRIV_LVL_U, 34'h1000, PMP_ACC_WRITE, 1, 1, 0);
      req(1, PRIV_LVL_U, 34'h8000, PMP_ACC_READ, 1, 0, 0);
      tick();
      req_valid = '0;
      exp_st(0, 1, "dual fault_valid");
      exp_st(1, 0, "dual fault_chan");
      exp_st(2, 34'h1000, "dual fault_addr");
      exp_st(3, PMP_ACC_WRITE, "dual fault_type");
      exp_st(4, 2, "dual count");
      req(1, PRIV_LVL_U, 34'h9000, PMP_ACC_READ, 1, 0, 0);
      tick();
      req_valid = '0;
      exp_st(1, 0, "sticky fault_chan");
      exp_st(2, 34'h1000, "sticky fault_addr");
      exp_st(4, 3, "sticky count");
      req(1, PRIV_LVL_U, 34'hA000, PMP_ACC_EXEC, 1, 0, 0);
      fault_clear = 1'b1;
      tick();
      fault_clear = 1'b0;
      req_valid = '0;
      exp_st(0, 1, "clr+ev fault_valid");
      exp_st(1, 1, "clr+ev fault_chan");
      exp_st(2, 34'hA000, "clr+ev fault_addr");
      exp_st(3, PMP_ACC_EXEC, "clr+ev fault_type");
      exp_st(4, 1, "clr+ev count");
      tick();

      // saturation, then reset mid-burst
      fault_clear = 1'b1;
      tick();
      fault_clear = 1'b0;
      for (int i = 0; i < 32767; i++) begin
         req(0, PRIV_LVL_U, 34'h8000, PMP_ACC_READ, 1, 0, 0);
         req(1, PRIV_LVL_U, 34'h8000, PMP_ACC_WRITE, 1, 0, 0);
         tick();
      end
      exp_st(4, 16'hFFFE, "count FFFE");
      req(0, PRIV_LVL_U, 34'h8000, PMP_ACC_READ, 1, 0, 0);
      req(1, PRIV_LVL_U, 34'h8000, PMP_ACC_WRITE, 1, 0, 0);
      tick();
      exp_st(4, 16'hFFFF, "count sat");
      req(0, PRIV_LVL_U, 34'h8000, PMP_ACC_READ, 1, 0, 0);
      req(1, PRIV_LVL_U, 34'h8000, PMP_ACC_WRITE, 1, 0, 0);
      tick();
      exp_st(4, 16'hFFFF, "count hold");
      req(0, PRIV_LVL_U, 34'h8000, PMP_ACC_READ, 1, 0, 0);
      req(1, PRIV_LVL_U, 34'h8000, PMP_ACC_WRITE, 1, 0, 0);
      tick();
      rst = 1'b1;
      tick();
      exp_st(5, 0, "mid rst req_ready");
      exp_st(6, 0, "mid rst rsp_valid");
      exp_st(7, 0, "mid rst rsp ch0");
      exp_st(8, 0, "mid rst rsp ch1");
      exp_st(0, 0, "mid rst fault_valid");
      exp_st(1, 0, "mid rst fault_chan");
      exp_st(2, 0, "mid rst fault_addr");
      exp_st(3, 0, "mid rst fault_type");
      exp_st(4, 0, "mid rst count");
      req_valid = '0;
      tick();
      rst = 1'b0;
      exp_st(5, 3, "ready after mid rst");
      exp_st(9, 0, "leftover responses");
      tick();
      tick();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
